buf_loader: RTL and testbench
=============================

# buf_loader

Controller that sequences the 128-byte input buffer (`buffin`) in the input path. It shares the buffer's single write port between two byte producers, the keypad and the serial receiver, using round-robin arbitration. It also drains the buffer into program RAM one frame at a time, where a frame ends with the two-byte marker 0x00 0x80 that the buffer flags on `endf`. It sits between the producers, the buffer, and the program-RAM write port. It drives the buffer's `wre`, `read` and `data` inputs and monitors `count`, `out` and `endf`.

## Interface
- `ADDR_W`, 8: program-RAM address width.
- `TIMEOUT`, 16'd50000: number of consecutive empty cycles while loading before the block aborts.
- `clk` in 1: system clock.
- `clr` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame load. Ignored unless the FSM is in IDLE, DONE or ERR.
- `req_a` in 1, `dat_a` in 8: keypad write request and byte.
- `req_b` in 1, `dat_b` in 8: serial write request and byte.
- `gnt_a` out 1, `gnt_b` out 1: combinational grants. A grant means the byte is written on this clock edge.
- `buf_wre` out 1, `buf_data` out 8: drive the buffer's `wre` and `data` inputs.
- `buf_read` out 1: drives the buffer's `read` input.
- `buf_count` in 7, `buf_out` in 8, `buf_endf` in 1: buffer status inputs.
- `mem_we` out 1, `mem_addr` out ADDR_W, `mem_data` out 8: program-RAM write port.
- `busy` out 1, `done` out 1, `err` out 1: load status.
- `len` out ADDR_W: number of bytes stored in the last frame.

## Operation
- **Write arbiter.** A write is eligible when its request is high, `buf_count` is not 127, and `buf_read` is low that cycle.
  - If one eligible requester: grant it.
  - If both: grant the one not granted last. A 1-bit `last` register updates on every grant.
  - `buf_wre` = `gnt_a | gnt_b`. `buf_data` is the granted requester's byte, else 0.
  - The buffer overwrites its last slot when full, so full must block writes.
  - The buffer ignores `read` while `wre` is high, so reads take priority over writes.
- **Loader FSM.** States are IDLE, POLL, RD, CAP, DONE, ERR.
  - IDLE/DONE/ERR → POLL on `start`: clear `mem_addr`, clear the timeout counter, clear `done` and `err`.
  - POLL:
    - If `buf_count` ≠ 0 → RD.
    - Otherwise increment the timeout counter. When it reaches TIMEOUT → ERR.
    - The FSM uses `buf_count`, not the buffer's `empt`, because `empt` lags by one cycle.
  - RD: `buf_read` = 1 for this one cycle, then → CAP. The timeout counter clears.
  - CAP: `buf_out` now holds the byte that was read.
    - `mem_we` = 1 and `mem_data` = `buf_out`, written at the current `mem_addr`.
    - If `buf_endf` is high → DONE: `len` = `mem_addr` + 1, `done` = 1.
    - Else if `mem_addr` = 2^ADDR_W − 1 → ERR (overflow). The byte is still written.
    - Otherwise `mem_addr` increments and → POLL.
  - `busy` = 1 in POLL, RD and CAP.
- **Marker bytes.** Both bytes of the 0x00 0x80 end marker are stored in RAM and included in `len`.
- **Drain rate.** One byte every 3 cycles at most: POLL, RD, CAP.

## Timing
- **Reset.** `clr` is sampled on the rising edge of `clk`. It overrides every other input, including mid-load.
  - Values after reset: IDLE; `mem_addr`, `len` and the timeout counter = 0; `busy`, `done`, `err`, `mem_we` and `buf_read` = 0; `last` = B, so A wins the first tie.
  - The buffer has its own reset and is not reset by this block.
- **Grant latency.** Zero cycles: combinational from `req_*`, `buf_count` and state. A requester holds its request until it sees its grant.
- **Capture.** Read issued in RD at edge N; `buf_out` and `buf_endf` are valid after edge N; `mem_we` is sampled at edge N+1.
- **Status outputs.** `done` and `err` are levels that stay set until the next `start` or `clr`. `mem_we` is registered-free: it is a decode of CAP.
- **Start while busy.** A `start` pulse during POLL, RD or CAP is ignored.
- **Write and read in the same cycle.** Any write request raised during RD is stalled one cycle.

## Structure
- Shared package `buf_pkg` holds:
  - FSM state encoding, 3 bits;
  - `BUF_DEPTH_MAX` = 7'd127;
  - end-marker constants 8'h00 and 8'h80, also for use by the buffer.
- One natural sub-module, `rr_arb2`: the 2-way round-robin arbiter with the `last` register. It takes an external `block` input driven by `buf_read | full`.
- The loader FSM lives in `buf_loader`.

## Test plan
- **Tie.** `req_a` and `req_b` held with 0x11/0x22 for 4 cycles, count < 127 → grants A, B, A, B; `buf_data` = 11, 22, 11, 22.
- **Full.** `buf_count` = 127 with `req_a` high → `gnt_a` = 0 and `buf_wre` = 0 until count drops.
- **Frame load.** Buffer preloaded with 41, 42, 00, 80, then `start` → `mem_we` at addresses 0..3 with data 41, 42, 00, 80; `done` = 1, `len` = 4, `busy` = 0; 12 cycles from POLL.
- **Read collision.** `req_b` asserted during the RD cycle → `gnt_b` = 0 that cycle and 1 the next; `buf_read` and `buf_wre` are never high together.
- **Timeout.** TIMEOUT = 10, `start` with count = 0 → `err` = 1 after 10 POLL cycles, `mem_we` never asserted.
- **Overflow and reset.** ADDR_W = 2 with 5 non-marker bytes → ERR after the write at address 3. A `clr` mid-load → IDLE next cycle with all outputs at their reset values.

Source files
------------

// File: rtl/buf_pkg.sv
// rtl/buf_pkg.sv - shared types and constants for the input-buffer loader
package buf_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_POLL = 3'd1,
      S_RD   = 3'd2,
      S_CAP  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [6:0] BUF_DEPTH_MAX = 7'd127;

   // Frame end marker, first and second byte; the buffer raises endf on the second
   localparam logic [7:0] END_MARK0 = 8'h00;
   localparam logic [7:0] END_MARK1 = 8'h80;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin write arbiter with an external block input
module rr_arb2 (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_block,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   logic r_last;
   logic w_elig_a;
   logic w_elig_b;

   assign w_elig_a = i_req_a & ~i_block;
   assign w_elig_b = i_req_b & ~i_block;

   // r_last = 1 means B was granted last, so A wins the next tie
   assign o_gnt_a = w_elig_a & (~w_elig_b | r_last);
   assign o_gnt_b = w_elig_b & (~w_elig_a | ~r_last);

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_last <= 1'b1;
      end else if (o_gnt_a) begin
         r_last <= 1'b0;
      end else if (o_gnt_b) begin
         r_last <= 1'b1;
      end
   end

endmodule

// File: rtl/buf_loader.sv
// rtl/buf_loader.sv - shares the buffer write port and drains frames into program RAM
module buf_loader
   import buf_pkg::*;
#(
   parameter int          ADDR_W  = 8,
   parameter logic [15:0] TIMEOUT = 16'd50000
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic              i_start,
   input  logic              i_req_a,
   input  logic [7:0]        i_dat_a,
   input  logic              i_req_b,
   input  logic [7:0]        i_dat_b,
   output logic              o_gnt_a,
   output logic              o_gnt_b,
   output logic              o_buf_wre,
   output logic [7:0]        o_buf_data,
   output logic              o_buf_read,
   input  logic [6:0]        i_buf_count,
   input  logic [7:0]        i_buf_out,
   input  logic              i_buf_endf,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_data,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_len
);

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_len;
   logic [15:0]       r_tmo;
   logic              r_done;
   logic              r_err;

   logic w_read;
   logic w_block;
   logic w_gnt_a;
   logic w_gnt_b;

   // The buffer drops a read when wre is high, so a read cycle blocks all writes
   assign w_read  = (r_state == S_RD);
   assign w_block = w_read | (i_buf_count == BUF_DEPTH_MAX);

   rr_arb2 u_arb (
      .i_clk   (i_clk),
      .i_clr   (i_clr),
      .i_req_a (i_req_a),
      .i_req_b (i_req_b),
      .i_block (w_block),
      .o_gnt_a (w_gnt_a),
      .o_gnt_b (w_gnt_b)
   );

   assign o_gnt_a    = w_gnt_a;
   assign o_gnt_b    = w_gnt_b;
   assign o_buf_wre  = w_gnt_a | w_gnt_b;
   assign o_buf_data = w_gnt_a ? i_dat_a : (w_gnt_b ? i_dat_b : 8'h00);
   assign o_buf_read = w_read;

   assign o_mem_we   = (r_state == S_CAP);
   assign o_mem_addr = r_addr;
   assign o_mem_data = i_buf_out;
   assign o_busy     = (r_state == S_POLL) | (r_state == S_RD) | (r_state == S_CAP);
   assign o_done     = r_done;
   assign o_err      = r_err;
   assign o_len      = r_len;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_len   <= '0;
         r_tmo   <= 16'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (i_start) begin
                  r_addr  <= '0;
                  r_tmo   <= 16'd0;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= S_POLL;
               end
            end
            // buf_count is used rather than empt, which trails a write by a cycle
            S_POLL: begin
               if (i_buf_count != 7'd0) begin
                  r_state <= S_RD;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
                  if (r_tmo == TIMEOUT - 16'd1) begin
                     r_err   <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end
            S_RD: begin
               r_tmo   <= 16'd0;
               r_state <= S_CAP;
            end
            S_CAP: begin
               if (i_buf_endf) begin
                  r_len   <= r_addr + 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_addr == {ADDR_W{1'b1}}) begin
                  r_err   <= 1'b1;
                  r_state <= S_ERR;
               end else begin
                  r_addr  <= r_addr + 1'b1;
                  r_state <= S_POLL;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_buf_loader.sv
// tb/tb_buf_loader.sv - self-checking bench for buf_loader with a behavioural buffer model
`timescale 1ns/1ps
module tb_buf_loader;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic       start2 = 1'b0;
   logic       req_a = 1'b0;
   logic       req_b = 1'b0;
   logic [7:0] dat_a = 8'h00;
   logic [7:0] dat_b = 8'h00;
   logic       sel = 1'b0;
   logic       flush = 1'b0;
   logic       full_ovr = 1'b0;

   logic [6:0] q_count = 7'd0;
   logic [7:0] m_out = 8'h00;
   logic       m_endf = 1'b0;
   logic [7:0] m_prev = 8'hff;
   logic [7:0] m_b;
   logic [7:0] fifo[$];
   logic [15:0] exp_q[$];
   logic [6:0] buf_count;

   logic       gnt_a1, gnt_b1, wre1, read1, we1, busy1, done1, err1;
   logic [7:0] bdata1, mdata1, addr1, len1;
   logic       gnt_a2, gnt_b2, wre2, read2, we2, busy2, done2, err2;
   logic [7:0] bdata2, mdata2;
   logic [1:0] addr2, len2;

   logic       w_gnt_a, w_wre, w_read, w_we;
   logic [7:0] w_bdata, w_mdata, w_maddr;

   int n_checks = 0;
   int n_pass = 0;
   int cyc;

   always #5 clk = ~clk;

   assign buf_count = full_ovr ? 7'd127 : q_count;
   assign w_gnt_a = sel ? gnt_a2 : gnt_a1;
   assign w_wre   = sel ? wre2 : wre1;
   assign w_bdata = sel ? bdata2 : bdata1;
   assign w_read  = sel ? read2 : read1;
   assign w_we    = sel ? we2 : we1;
   assign w_mdata = sel ? mdata2 : mdata1;
   assign w_maddr = sel ? {6'd0, addr2} : addr1;

   buf_loader #(.ADDR_W(8), .TIMEOUT(16'd10)) dut (
      .i_clk(clk), .i_clr(clr), .i_start(start),
      .i_req_a(req_a), .i_dat_a(dat_a), .i_req_b(req_b), .i_dat_b(dat_b),
      .o_gnt_a(gnt_a1), .o_gnt_b(gnt_b1), .o_buf_wre(wre1), .o_buf_data(bdata1),
      .o_buf_read(read1), .i_buf_count(buf_count), .i_buf_out(m_out), .i_buf_endf(m_endf),
      .o_mem_we(we1), .o_mem_addr(addr1), .o_mem_data(mdata1),
      .o_busy(busy1), .o_done(done1), .o_err(err1), .o_len(len1)
   );

   buf_loader #(.ADDR_W(2), .TIMEOUT(16'd10)) dut2 (
      .i_clk(clk), .i_clr(clr), .i_start(start2),
      .i_req_a(req_a), .i_dat_a(dat_a), .i_req_b(req_b), .i_dat_b(dat_b),
      .o_gnt_a(gnt_a2), .o_gnt_b(gnt_b2), .o_buf_wre(wre2), .o_buf_data(bdata2),
      .o_buf_read(read2), .i_buf_count(buf_count), .i_buf_out(m_out), .i_buf_endf(m_endf),
      .o_mem_we(we2), .o_mem_addr(addr2), .o_mem_data(mdata2),
      .o_busy(busy2), .o_done(done2), .o_err(err2), .o_len(len2)
   );

   // Buffer: write wins over read, out/endf update on the read edge
   always @(posedge clk) begin
      if (flush) begin
         fifo.delete();
         m_prev = 8'hff;
      end else if (w_wre) begin
         if (fifo.size() < 127) fifo.push_back(w_bdata);
      end else if (w_read && fifo.size() > 0) begin
         m_b = fifo.pop_front();
         m_out  <= m_b;
         m_endf <= (m_prev == 8'h00) && (m_b == 8'h80);
         m_prev = m_b;
      end
      q_count <= 7'(fifo.size());
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!clr) begin
         if (w_we) begin
            if (exp_q.size() == 0) begin
               chk("mem_we_unexpected", 32'(w_maddr), 32'hffff);
            end else begin
               chk("mem_addr", 32'(w_maddr), 32'(exp_q[0][15:8]));
               chk("mem_data", 32'(w_mdata), 32'(exp_q[0][7:0]));
               void'(exp_q.pop_front());
            end
         end
         if (w_read) chk("rd_wr_excl", 32'(w_wre), 32'd0);
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int n;
      req_a = 1'b1;
      dat_a = b;
      n = 0;
      #1;
      while (!w_gnt_a && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n == 20) chk("push_timeout", 32'd0, 32'd1);
      @(negedge clk);
      req_a = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse(input bit two);
      if (two) start2 = 1'b1; else start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      start2 = 1'b0;
      cyc = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] frm[4];
      repeat (3) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done1), 0);
      chk("rst_err", 32'(err1), 0);
      chk("rst_mem_we", 32'(we1), 0);
      chk("rst_read", 32'(read1), 0);
      chk("rst_len", 32'(len1), 0);

      // Tie: A wins first after reset, then alternation
      @(negedge clk);
      req_a = 1'b1; dat_a = 8'h11;
      req_b = 1'b1; dat_b = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("tie_gnt_a", 32'(gnt_a1), 32'((i % 2) == 0));
         chk("tie_gnt_b", 32'(gnt_b1), 32'((i % 2) == 1));
         chk("tie_data", 32'(bdata1), (i % 2 == 0) ? 32'h11 : 32'h22);
         @(negedge clk);
      end
      req_a = 1'b0; req_b = 1'b0;

      // Full blocks writes until the count drops
      full_ovr = 1'b1; req_a = 1'b1; dat_a = 8'h33;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("full_gnt_a", 32'(gnt_a1), 0);
         chk("full_wre", 32'(wre1), 0);
         @(negedge clk);
      end
      full_ovr = 1'b0;
      #1;
      chk("unfull_gnt_a", 32'(gnt_a1), 1);
      @(negedge clk);
      req_a = 1'b0;
      do_flush();

      // Frame load
      frm = '{8'h41, 8'h42, 8'h00, 8'h80};
      for (int i = 0; i < 4; i++) begin
         push_byte(frm[i]);
         exp_q.push_back({8'(i), frm[i]});
      end
      pulse(0);
      while (!done1 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("frame_cycles", 32'(cyc), 12);
      chk("frame_done", 32'(done1), 1);
      chk("frame_len", 32'(len1), 4);
      chk("frame_busy", 32'(busy1), 0);
      chk("frame_sb_empty", 32'(exp_q.size()), 0);

      // Read collision: a write raised in RD waits one cycle
      frm = '{8'h55, 8'h00, 8'h80, 8'h00};
      for (int i = 0; i < 3; i++) begin
         push_byte(frm[i]);
         exp_q.push_back({8'(i), frm[i]});
      end
      pulse(0);
      while (!read1 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("col_saw_read", 32'(read1), 1);
      req_b = 1'b1; dat_b = 8'h66;
      #1;
      chk("col_gnt_b_rd", 32'(gnt_b1), 0);
      chk("col_wre_rd", 32'(wre1), 0);
      @(negedge clk);
      #1;
      chk("col_gnt_b_next", 32'(gnt_b1), 1);
      chk("col_data_next", 32'(bdata1), 32'h66);
      @(negedge clk);
      req_b = 1'b0;
      cyc = 0;
      while (!done1 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("col_done", 32'(done1), 1);
      chk("col_len", 32'(len1), 3);
      chk("col_sb_empty", 32'(exp_q.size()), 0);
      do_flush();

      // Timeout with an empty buffer
      pulse(0);
      while (!err1 && cyc < 50) begin @(negedge clk); cyc++; end
      chk("tmo_cycles", 32'(cyc), 10);
      chk("tmo_err", 32'(err1), 1);
      chk("tmo_done_cleared", 32'(done1), 0);
      chk("tmo_busy", 32'(busy1), 0);
      repeat (3) @(negedge clk);
      chk("tmo_err_held", 32'(err1), 1);

      // Overflow on the 2-bit address instance
      sel = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         push_byte(8'(i + 1));
         if (i < 4) exp_q.push_back({8'(i), 8'(i + 1)});
      end
      pulse(1);
      while (!err2 && cyc < 100) begin @(negedge clk); cyc++; end
      chk("ovf_cycles", 32'(cyc), 12);
      chk("ovf_err", 32'(err2), 1);
      chk("ovf_done", 32'(done2), 0);
      chk("ovf_busy", 32'(busy2), 0);
      chk("ovf_sb_empty", 32'(exp_q.size()), 0);
      do_flush();
      sel = 1'b0;
      @(negedge clk);

      // Reset in the middle of a load
      frm = '{8'h10, 8'h20, 8'h00, 8'h80};
      for (int i = 0; i < 4; i++) push_byte(frm[i]);
      exp_q.push_back({8'd0, 8'h10});
      pulse(0);
      while (!(read1 && addr1 == 8'd1) && cyc < 50) begin @(negedge clk); cyc++; end
      chk("clr_reached_rd", 32'(addr1), 1);
      clr = 1'b1;
      @(negedge clk);
      #1;
      chk("clr_busy", 32'(busy1), 0);
      chk("clr_err", 32'(err1), 0);
      chk("clr_done", 32'(done1), 0);
      chk("clr_mem_we", 32'(we1), 0);
      chk("clr_read", 32'(read1), 0);
      chk("clr_addr", 32'(addr1), 0);
      chk("clr_len", 32'(len1), 0);
      chk("clr_sb_empty", 32'(exp_q.size()), 0);
      clr = 1'b0;
      do_flush();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
